escalonador_medida: RTL and testbench

ESCALONADOR_MEDIDA -- requirements
Module: escalonador_medida

---
 rtl/escalonador_medida.sv | 132 +++++++++++++
 tb/tb_escalonador_medida.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_medida.sv
// escalonador_medida: schedules distance measurements on a sensor interface.
// In periodic mode (ligar=1) a measurement starts every PERIODO cycles spent in
// ESPERA; unico starts a single measurement. Each request gets up to MAX_TENT
// attempts. An attempt fails on timeout or on an out-of-range reading, and each
// failure pulses reset_sensor to the sensor interface.
//
// Handshake with the sensor interface: medir is a one-cycle start strobe.
// The block then waits for pronto_sensor, a one-cycle strobe qualifying
// medida_sensor, and accepts it only while waiting (AGUARDA). A pronto_sensor
// seen in any other state is ignored. valido is a one-cycle strobe qualifying
// the new value on dado; there is no back-pressure on either side.
module escalonador_medida #(
  parameter int PERIODO  = 12500000,
  parameter int TIMEOUT  = 2500000,
  parameter int MAX_TENT = 3,
  parameter int LIMITE   = 400
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        unico,
  input  logic        pronto_sensor,
  input  logic [11:0] medida_sensor,
  output logic        medir,
  output logic        reset_sensor,
  output logic [11:0] dado,
  output logic        valido,
  output logic        erro,
  output logic [3:0]  db_estado
);

  // Each counter only has to reach its terminal value (PERIODO-1, TIMEOUT-1,
  // MAX_TENT), so these widths never wrap before the terminal count.
  localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int AW = $clog2(MAX_TENT + 1);

  localparam logic [PW-1:0] P_FIM = PW'(PERIODO - 1);
  localparam logic [TW-1:0] T_FIM = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] T_MAX = AW'(MAX_TENT);
  localparam logic [12:0]   LIM   = 13'(LIMITE);

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    DISPARA  = 4'd2,
    AGUARDA  = 4'd3,
    REGISTRA = 4'd4,
    FALHA    = 4'd5,
    RECUPERA = 4'd6
  } estado_t;

  estado_t       estado;
  estado_t       prox;
  logic [PW-1:0] cnt_per;
  logic [TW-1:0] cnt_to;
  logic [AW-1:0] tent;
  logic [AW-1:0] tent_inc;
  logic          leitura_ok;

  assign tent_inc   = tent + AW'(1);
  assign leitura_ok = ({1'b0, medida_sensor} <= LIM);
  assign db_estado  = estado;

  // Next-state decode; any code outside the defined set falls back to INICIAL.
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:  prox = ESPERA;
      ESPERA:   prox = (unico || (ligar && cnt_per == P_FIM)) ? DISPARA : ESPERA;
      DISPARA:  prox = AGUARDA;
      AGUARDA: begin
        if (pronto_sensor)        prox = leitura_ok ? REGISTRA : FALHA;
        else if (cnt_to == T_FIM) prox = FALHA;
        else                      prox = AGUARDA;
      end
      REGISTRA: prox = ESPERA;
      FALHA:    prox = (tent_inc < T_MAX) ? RECUPERA : ESPERA;
      RECUPERA: prox = DISPARA;
      default:  prox = INICIAL;
    endcase
  end

  // State register; the strobes are flopped from the next state so they line
  // up with the state that owns them and never glitch.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= INICIAL;
      medir        <= 1'b0;
      reset_sensor <= 1'b0;
      valido       <= 1'b0;
    end else begin
      estado       <= prox;
      medir        <= (prox == DISPARA);
      reset_sensor <= (prox == FALHA);
      valido       <= (prox == REGISTRA);
    end
  end

  // Period counter: runs only while waiting with ligar=1, cleared on any exit.
  always_ff @(posedge clock) begin
    if (reset || estado != ESPERA || prox != ESPERA || !ligar) cnt_per <= '0;
    else                                                       cnt_per <= cnt_per + PW'(1);
  end

  // Timeout counter: counts cycles spent waiting for pronto_sensor.
  always_ff @(posedge clock) begin
    if (reset || estado != AGUARDA) cnt_to <= '0;
    else                            cnt_to <= cnt_to + TW'(1);
  end

  // Attempt counter: one step per failure, cleared on success or exhaustion.
  always_ff @(posedge clock) begin
    if (reset || estado == INICIAL || estado == REGISTRA) tent <= '0;
    else if (estado == FALHA)                             tent <= (tent_inc < T_MAX) ? tent_inc : '0;
  end

  // Result and sticky error: a good reading loads dado and clears erro;
  // the final failed attempt of a request raises erro.
  always_ff @(posedge clock) begin
    if (reset) begin
      dado <= '0;
      erro <= 1'b0;
    end else if (estado == AGUARDA && prox == REGISTRA) begin
      dado <= medida_sensor;
      erro <= 1'b0;
    end else if (estado == FALHA && prox == ESPERA) begin
      erro <= 1'b1;
    end
  end

endmodule

// File: tb/tb_escalonador_medida.sv
// Bench for escalonador_medida: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a reference model.
module tb_escalonador_medida;

  localparam int PER  = 20;
  localparam int TO   = 10;
  localparam int MAXT = 3;
  localparam int LIM  = 400;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ligar = 1'b0;
  logic        unico = 1'b0;
  logic        pronto_sensor = 1'b0;
  logic [11:0] medida_sensor = '0;
  logic        medir;
  logic        reset_sensor;
  logic [11:0] dado;
  logic        valido;
  logic        erro;
  logic [3:0]  db_estado;

  always #5 clk = ~clk;

  escalonador_medida #(
    .PERIODO(PER), .TIMEOUT(TO), .MAX_TENT(MAXT), .LIMITE(LIM)
  ) dut (
    .clock(clk), .reset(reset), .ligar(ligar), .unico(unico),
    .pronto_sensor(pronto_sensor), .medida_sensor(medida_sensor),
    .medir(medir), .reset_sensor(reset_sensor), .dado(dado),
    .valido(valido), .erro(erro), .db_estado(db_estado)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- sensor responder ----------------
  // On every medir, answer after resp_lat cycles (0 = never answer).
  int          resp_lat  = 0;
  logic [11:0] resp_val  = '0;
  logic [11:0] val_q[$];
  bit          resp_rand = 1'b0;
  int          pend      = 0;
  logic [11:0] pend_val  = '0;

  always @(negedge clk) begin
    pronto_sensor = 1'b0;
    medida_sensor = 12'($urandom);
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        pronto_sensor = 1'b1;
        medida_sensor = pend_val;
      end
    end
    if (medir) begin
      if (resp_rand) begin
        pend = $urandom_range(0, 13);
        case ($urandom_range(0, 3))
          0:       pend_val = 12'($urandom_range(LIM, LIM + 1));
          1:       pend_val = 12'($urandom_range(LIM + 1, 4095));
          default: pend_val = 12'($urandom_range(0, LIM));
        endcase
      end else begin
        pend     = resp_lat;
        pend_val = (val_q.size() > 0) ? val_q.pop_front() : resp_val;
      end
    end
  end

  // ---------------- pulse monitor ----------------
  int cyc = 0;
  int medir_t[$];
  int rs_t[$];
  int n_val = 0;

  always @(negedge clk) begin
    cyc++;
    if (medir)        medir_t.push_back(cyc);
    if (reset_sensor) rs_t.push_back(cyc);
    if (valido)       n_val++;
  end

  // ---------------- reference model ----------------
  // Tracks where the scheduler is in terms of the documented state codes and
  // the counts that govern each phase; outputs follow directly from the phase.
  int          m_st = 0;
  int          m_esperou = 0;
  int          m_aguardou = 0;
  int          m_falhas = 0;
  logic [11:0] m_dado = '0;
  logic        m_erro = 1'b0;
  logic [11:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_esperou = 0; m_aguardou = 0; m_falhas = 0;
      m_dado = '0; m_erro = 1'b0;
    end else begin
      case (m_st)
        0: begin m_esperou = 0; m_aguardou = 0; m_falhas = 0; m_st = 1; end
        1: begin
          if (unico || (ligar && m_esperou + 1 == PER)) begin
            m_esperou = 0; m_st = 2;
          end else begin
            m_esperou = ligar ? m_esperou + 1 : 0;
          end
        end
        2: begin m_aguardou = 0; m_st = 3; end
        3: begin
          m_aguardou++;
          if (pronto_sensor && int'(medida_sensor) <= LIM) begin
            m_dado = medida_sensor; m_erro = 1'b0; m_st = 4;
            exp_q.push_back(medida_sensor);
          end else if (pronto_sensor || m_aguardou == TO) begin
            m_st = 5;
          end
        end
        4: begin m_falhas = 0; m_st = 1; end
        5: begin
          m_falhas++;
          if (m_falhas < MAXT) m_st = 6;
          else begin m_erro = 1'b1; m_falhas = 0; m_st = 1; end
        end
        6: m_st = 2;
        default: m_st = 0;
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("medir", medir, m_st == 2);
      chk("reset_sensor", reset_sensor, m_st == 5);
      chk("valido", valido, m_st == 4);
      chk("erro", erro, m_erro);
      chk("dado", dado, m_dado);
      chk("db_estado", db_estado, m_st);
      if (m_st == 4) begin
        if (exp_q.size() == 0) chk("fila_dado", 0, 1);
        else                   chk("dado_valido", dado, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulso_unico;
    @(negedge clk); unico = 1'b1;
    @(negedge clk); unico = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int m0, r0, v0, t;
    bit achou;

    // reset
    ciclos(3);
    cmp_en = 1'b1;
    chk("rst_medir", medir, 0);
    chk("rst_dado", dado, 0);
    chk("rst_erro", erro, 0);
    chk("rst_estado", db_estado, 0);
    reset = 1'b0;
    ciclos(1);
    chk("pos_rst_estado", db_estado, 1);
    ciclos(5);
    chk("sem_medir_pos_rst", medir_t.size(), 0);

    // single measurement, answer after 5 cycles
    resp_lat = 5; resp_val = 12'h0A5;
    m0 = medir_t.size(); v0 = n_val;
    pulso_unico();
    ciclos(60);
    chk("unico_medir", medir_t.size() - m0, 1);
    chk("unico_valido", n_val - v0, 1);
    chk("unico_dado", dado, 12'h0A5);
    chk("unico_ocioso", db_estado, 1);

    // sensor never answers: three attempts then erro
    resp_lat = 0;
    m0 = medir_t.size(); r0 = rs_t.size(); v0 = n_val;
    pulso_unico();
    ciclos(60);
    chk("to_medir", medir_t.size() - m0, 3);
    chk("to_reset_sensor", rs_t.size() - r0, 3);
    chk("to_valido", n_val - v0, 0);
    chk("to_erro", erro, 1);
    chk("to_dado", dado, 12'h0A5);
    if (medir_t.size() - m0 == 3 && rs_t.size() - r0 == 3)
      for (int i = 0; i < 3; i++)
        chk("to_intervalo", rs_t[r0 + i] - medir_t[m0 + i], TO + 1);

    // out-of-range reading, then good retry; clears prior erro
    resp_lat = 3; val_q.push_back(12'h1F4); val_q.push_back(12'h0C8);
    m0 = medir_t.size(); r0 = rs_t.size(); v0 = n_val;
    pulso_unico();
    ciclos(40);
    chk("fx_medir", medir_t.size() - m0, 2);
    chk("fx_reset_sensor", rs_t.size() - r0, 1);
    chk("fx_valido", n_val - v0, 1);
    chk("fx_dado", dado, 12'h0C8);
    chk("fx_erro", erro, 0);

    // answer on the last timeout cycle wins over timeout
    resp_lat = TO; resp_val = 12'h010;
    r0 = rs_t.size(); v0 = n_val;
    pulso_unico();
    ciclos(30);
    chk("lim_reset_sensor", rs_t.size() - r0, 0);
    chk("lim_valido", n_val - v0, 1);
    chk("lim_dado", dado, 12'h010);

    // periodic mode
    resp_lat = 3; resp_val = 12'h064;
    m0 = medir_t.size(); v0 = n_val;
    @(negedge clk); ligar = 1'b1;
    ciclos(80);
    ligar = 1'b0;
    chk("per_medir", medir_t.size() - m0, 3);
    chk("per_valido", n_val - v0, 3);
    chk("per_dado", dado, 12'h064);
    chk("per_erro", erro, 0);
    if (medir_t.size() - m0 == 3)
      for (int i = 1; i < 3; i++)
        chk("per_intervalo", medir_t[m0 + i] - medir_t[m0 + i - 1], PER + 5);
    ciclos(30);

    // reset in the middle of AGUARDA, late answer must be ignored
    resp_lat = 8; resp_val = 12'h123;
    pulso_unico();
    achou = 1'b0;
    for (t = 0; t < 20 && !achou; t++) begin
      if (db_estado == 4'd3) achou = 1'b1;
      else ciclos(1);
    end
    chk("espera_aguarda", achou, 1);
    reset = 1'b1;
    ciclos(1);
    reset = 1'b0;
    chk("rst_ag_medir", medir, 0);
    chk("rst_ag_valido", valido, 0);
    chk("rst_ag_dado", dado, 0);
    chk("rst_ag_erro", erro, 0);
    chk("rst_ag_estado", db_estado, 0);
    m0 = medir_t.size(); v0 = n_val;
    ciclos(1);
    chk("rst_ag_espera", db_estado, 1);
    ciclos(15);
    chk("rst_ag_sem_medir", medir_t.size() - m0, 0);
    chk("rst_ag_sem_valido", n_val - v0, 0);
    chk("rst_ag_dado_fim", dado, 0);

    // randomized traffic
    resp_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) ligar = ~ligar;
      unico = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 699) == 0);
    end
    @(negedge clk);
    unico = 1'b0; reset = 1'b0; ligar = 1'b0;
    ciclos(60);
    chk("fila_final", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
